// File: rtl/rvee_clint_pkg.sv
// Shared definitions for the CLINT: register offsets, AXI response codes,
// FSM states, address decode and byte-strobe merge helpers.
package rvee_clint_pkg;

  localparam logic [15:0] OFF_MSIP        = 16'h0000;
  localparam logic [15:0] OFF_MTIMECMP_LO = 16'h4000;
  localparam logic [15:0] OFF_MTIMECMP_HI = 16'h4004;
  localparam logic [15:0] OFF_MTIME_LO    = 16'hBFF8;
  localparam logic [15:0] OFF_MTIME_HI    = 16'hBFFC;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_HAVE_AW,
    WR_HAVE_W,
    WR_RESP
  } wr_state_e;

  typedef enum logic {
    RD_IDLE,
    RD_RDATA
  } rd_state_e;

  typedef enum logic [2:0] {
    REG_MSIP,
    REG_CMP_LO,
    REG_CMP_HI,
    REG_TIME_LO,
    REG_TIME_HI,
    REG_NONE
  } reg_sel_e;

  // Exact 16-bit match, so misaligned offsets fall through to REG_NONE.
  function automatic reg_sel_e decode_addr(input logic [15:0] addr);
    case (addr)
      OFF_MSIP:        return REG_MSIP;
      OFF_MTIMECMP_LO: return REG_CMP_LO;
      OFF_MTIMECMP_HI: return REG_CMP_HI;
      OFF_MTIME_LO:    return REG_TIME_LO;
      OFF_MTIME_HI:    return REG_TIME_HI;
      default:         return REG_NONE;
    endcase
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/rvee_clint_if.sv
// AXI4-Lite slave bus into the CLINT (no AxPROT); master drives requests,
// slave drives ready/response signals.
interface rvee_clint_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic [AWIDTH-1:0]   s00_awaddr;
  logic                s00_awvalid;
  logic                s00_awready;
  logic [DWIDTH-1:0]   s00_wdata;
  logic [DWIDTH/8-1:0] s00_wstrb;
  logic                s00_wvalid;
  logic                s00_wready;
  logic [1:0]          s00_bresp;
  logic                s00_bvalid;
  logic                s00_bready;
  logic [AWIDTH-1:0]   s00_araddr;
  logic                s00_arvalid;
  logic                s00_arready;
  logic [DWIDTH-1:0]   s00_rdata;
  logic [1:0]          s00_rresp;
  logic                s00_rvalid;
  logic                s00_rready;

  modport master (
    output s00_awaddr, s00_awvalid, s00_wdata, s00_wstrb, s00_wvalid,
           s00_bready, s00_araddr, s00_arvalid, s00_rready,
    input  s00_awready, s00_wready, s00_bresp, s00_bvalid,
           s00_arready, s00_rdata, s00_rresp, s00_rvalid
  );

  modport slave (
    input  s00_awaddr, s00_awvalid, s00_wdata, s00_wstrb, s00_wvalid,
           s00_bready, s00_araddr, s00_arvalid, s00_rready,
    output s00_awready, s00_wready, s00_bresp, s00_bvalid,
           s00_arready, s00_rdata, s00_rresp, s00_rvalid
  );
endinterface

// File: rtl/rvee_clint_timer.sv
// 64-bit mtime counter advanced once every PRESCALE clocks; a software write
// to either word pre-empts that cycle's increment and merges bytes per strobe.
module rvee_clint_timer
  import rvee_clint_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_wr_lo,
  input  logic        i_wr_hi,
  input  logic [31:0] i_wr_data,
  input  logic [3:0]  i_wr_strb,
  output logic [63:0] o_mtime
);

  localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

  logic [15:0] r_presc;
  logic [63:0] r_mtime;
  logic        w_tick;

  assign w_tick = (r_presc == PS_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 16'd1;
    end
  end

  // Unwritten bytes keep the pre-increment value when a write lands on a tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mtime <= '0;
    end else if (i_wr_lo || i_wr_hi) begin
      if (i_wr_lo) r_mtime[31:0]  <= merge_bytes(r_mtime[31:0],  i_wr_data, i_wr_strb);
      if (i_wr_hi) r_mtime[63:32] <= merge_bytes(r_mtime[63:32], i_wr_data, i_wr_strb);
    end else if (w_tick) begin
      r_mtime <= r_mtime + 64'd1;
    end
  end

  assign o_mtime = r_mtime;

endmodule

// File: rtl/rvee_clint.sv
// Core-local interruptor: AXI4-Lite register file for msip, mtimecmp and mtime,
// driving level msip/mtip; AW and W are held independently, reads run in parallel.
module rvee_clint
  import rvee_clint_pkg::*;
#(
  parameter int AWIDTH   = 32,
  parameter int DWIDTH   = 32,
  parameter int PRESCALE = 1
) (
  input  logic         clk,
  input  logic         rst,
  rvee_clint_if.slave  s00,
  output logic         msip,
  output logic         mtip
);

  wr_state_e   r_wstate, w_wstate_nxt;
  rd_state_e   r_rstate, w_rstate_nxt;

  logic        r_aw_full, r_w_full;
  logic [15:0] r_awaddr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [1:0]  r_bresp;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;
  logic        r_msip;
  logic [63:0] r_mtimecmp;
  logic        r_mtip;

  logic        w_awready, w_wready, w_bvalid, w_arready, w_rvalid;
  logic        w_aw_hs, w_w_hs, w_ar_hs, w_do_write;
  reg_sel_e    w_wsel, w_rsel;
  logic        w_wr_err, w_rd_err;
  logic [31:0] w_rd_val;
  logic [63:0] w_mtime;
  logic        w_unused;

  assign w_aw_hs    = s00.s00_awvalid && w_awready;
  assign w_w_hs     = s00.s00_wvalid  && w_wready;
  assign w_ar_hs    = s00.s00_arvalid && w_arready;
  assign w_do_write = r_aw_full && r_w_full;
  assign w_wsel     = decode_addr(r_awaddr);
  assign w_wr_err   = (w_wsel == REG_NONE);
  assign w_rsel     = decode_addr(s00.s00_araddr[15:0]);
  assign w_unused   = ^{s00.s00_awaddr[AWIDTH-1:16], s00.s00_araddr[AWIDTH-1:16]};

  // ---------------- write channel ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wstate <= WR_IDLE;
    end else begin
      r_wstate <= w_wstate_nxt;
    end
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      WR_RESP: begin
        if (s00.s00_bready) w_wstate_nxt = WR_IDLE;
      end
      default: begin
        if (w_do_write)                   w_wstate_nxt = WR_RESP;
        else if (r_aw_full || w_aw_hs)    w_wstate_nxt = WR_HAVE_AW;
        else if (r_w_full || w_w_hs)      w_wstate_nxt = WR_HAVE_W;
        else                              w_wstate_nxt = WR_IDLE;
      end
    endcase
  end

  always_comb begin
    w_awready = (r_wstate != WR_RESP) && !r_aw_full;
    w_wready  = (r_wstate != WR_RESP) && !r_w_full;
    w_bvalid  = (r_wstate == WR_RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bresp   <= RESP_OKAY;
    end else if (w_do_write) begin
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
      r_bresp   <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
    end else begin
      if (w_aw_hs) begin
        r_aw_full <= 1'b1;
        r_awaddr  <= s00.s00_awaddr[15:0];
      end
      if (w_w_hs) begin
        r_w_full <= 1'b1;
        r_wdata  <= s00.s00_wdata;
        r_wstrb  <= s00.s00_wstrb;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_msip     <= 1'b0;
      r_mtimecmp <= '1;
    end else if (w_do_write) begin
      case (w_wsel)
        REG_MSIP:   if (r_wstrb[0]) r_msip <= r_wdata[0];
        REG_CMP_LO: r_mtimecmp[31:0]  <= merge_bytes(r_mtimecmp[31:0],  r_wdata, r_wstrb);
        REG_CMP_HI: r_mtimecmp[63:32] <= merge_bytes(r_mtimecmp[63:32], r_wdata, r_wstrb);
        default: ;
      endcase
    end
  end

  rvee_clint_timer #(
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_wr_lo   (w_do_write && (w_wsel == REG_TIME_LO)),
    .i_wr_hi   (w_do_write && (w_wsel == REG_TIME_HI)),
    .i_wr_data (r_wdata),
    .i_wr_strb (r_wstrb),
    .o_mtime   (w_mtime)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mtip <= 1'b0;
    end else begin
      r_mtip <= (w_mtime >= r_mtimecmp);
    end
  end

  // ---------------- read channel ----------------
  always_comb begin
    w_rd_val = '0;
    w_rd_err = 1'b0;
    case (w_rsel)
      REG_MSIP:    w_rd_val = {31'd0, r_msip};
      REG_CMP_LO:  w_rd_val = r_mtimecmp[31:0];
      REG_CMP_HI:  w_rd_val = r_mtimecmp[63:32];
      REG_TIME_LO: w_rd_val = w_mtime[31:0];
      REG_TIME_HI: w_rd_val = w_mtime[63:32];
      default:     w_rd_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rstate <= RD_IDLE;
    end else begin
      r_rstate <= w_rstate_nxt;
    end
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      RD_IDLE:  if (s00.s00_arvalid) w_rstate_nxt = RD_RDATA;
      RD_RDATA: if (s00.s00_rready)  w_rstate_nxt = RD_IDLE;
      default:  w_rstate_nxt = RD_IDLE;
    endcase
  end

  always_comb begin
    w_arready = (r_rstate == RD_IDLE);
    w_rvalid  = (r_rstate == RD_RDATA);
  end

  // Sampled at the AR handshake, so a same-cycle write is not yet visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rdata <= w_rd_val;
      r_rresp <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
    end
  end

  assign s00.s00_awready = w_awready;
  assign s00.s00_wready  = w_wready;
  assign s00.s00_bvalid  = w_bvalid;
  assign s00.s00_bresp   = r_bresp;
  assign s00.s00_arready = w_arready;
  assign s00.s00_rvalid  = w_rvalid;
  assign s00.s00_rdata   = r_rdata;
  assign s00.s00_rresp   = r_rresp;
  assign msip            = r_msip;
  assign mtip            = r_mtip;

endmodule

// File: tb/tb_rvee_clint.sv
// Directed bench for rvee_clint: register map, write/read handshake timing,
// mtime strobe merge, mtip compare, reset behaviour.
module tb_rvee_clint;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic msip, mtip;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc = 0;
  int   base;
  logic [31:0] d;
  logic [1:0]  r;
  logic        rv;

  rvee_clint_if #(.AWIDTH(32), .DWIDTH(32)) bus ();

  rvee_clint #(.AWIDTH(32), .DWIDTH(32), .PRESCALE(1)) dut (
    .clk  (clk),
    .rst  (rst),
    .s00  (bus),
    .msip (msip),
    .mtip (mtip)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the write channel idle; returns at a negedge.
  task automatic axi_write(input logic [15:0] a, input logic [31:0] dat,
                           input logic [3:0] s, output logic [1:0] resp);
    int n;
    bit aw_done, w_done, aw_now, w_now;
    bus.s00_awaddr  = {16'h0, a};
    bus.s00_wdata   = dat;
    bus.s00_wstrb   = s;
    bus.s00_awvalid = 1'b1;
    bus.s00_wvalid  = 1'b1;
    bus.s00_bready  = 1'b1;
    aw_done = 0; w_done = 0; n = 0;
    while (!(aw_done && w_done) && n < 50) begin
      aw_now = bus.s00_awvalid && bus.s00_awready;
      w_now  = bus.s00_wvalid && bus.s00_wready;
      @(posedge clk); @(negedge clk);
      if (aw_now) begin aw_done = 1; bus.s00_awvalid = 1'b0; end
      if (w_now)  begin w_done  = 1; bus.s00_wvalid  = 1'b0; end
      n++;
    end
    check("wr_handshake", 64'(aw_done && w_done), 1);
    n = 0;
    while (!bus.s00_bvalid && n < 50) begin @(negedge clk); n++; end
    check("wr_bvalid", 64'(bus.s00_bvalid), 1);
    resp = bus.s00_bresp;
    @(posedge clk); @(negedge clk);
  endtask

  // Called at a negedge; rv_next is rvalid in the cycle right after AR.
  task automatic axi_read(input logic [15:0] a, output logic [31:0] dat,
                          output logic [1:0] resp, output logic rv_next);
    int n;
    bit done;
    bus.s00_araddr  = {16'h0, a};
    bus.s00_arvalid = 1'b1;
    bus.s00_rready  = 1'b1;
    done = 0; n = 0;
    while (!done && n < 50) begin
      done = bus.s00_arready;
      @(posedge clk); @(negedge clk);
      n++;
    end
    bus.s00_arvalid = 1'b0;
    check("rd_handshake", 64'(done), 1);
    rv_next = bus.s00_rvalid;
    n = 0;
    while (!bus.s00_rvalid && n < 50) begin @(negedge clk); n++; end
    dat  = bus.s00_rdata;
    resp = bus.s00_rresp;
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.s00_awaddr = '0; bus.s00_awvalid = 0; bus.s00_wdata = '0; bus.s00_wstrb = '0;
    bus.s00_wvalid = 0;  bus.s00_bready = 1;  bus.s00_araddr = '0; bus.s00_arvalid = 0;
    bus.s00_rready = 1;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_awready", 64'(bus.s00_awready), 1);
    check("rst_wready",  64'(bus.s00_wready), 1);
    check("rst_arready", 64'(bus.s00_arready), 1);
    check("rst_bvalid",  64'(bus.s00_bvalid), 0);
    check("rst_rvalid",  64'(bus.s00_rvalid), 0);
    check("rst_bresp",   64'(bus.s00_bresp), 0);
    check("rst_rresp",   64'(bus.s00_rresp), 0);
    check("rst_rdata",   64'(bus.s00_rdata), 0);
    check("rst_msip",    64'(msip), 0);
    check("rst_mtip",    64'(mtip), 0);
    rst = 1'b0;
    base = cyc;

    // mtimecmp = 0x10: mtime is 16 after the 16th edge, mtip follows one edge later
    axi_write(16'h4004, 32'h0, 4'hF, r);
    check("cmp_hi_resp", 64'(r), 0);
    axi_write(16'h4000, 32'h10, 4'hF, r);
    while (cyc - base < 16) @(negedge clk);
    check("mtip_at_0x10", 64'(mtip), 0);
    @(negedge clk);
    check("mtip_after_0x10", 64'(mtip), 1);

    // AW at cycle 0, W at cycle 3, response at cycle 5
    @(negedge clk);
    check("c0_awready", 64'(bus.s00_awready), 1);
    bus.s00_awaddr = 32'h0; bus.s00_awvalid = 1; bus.s00_bready = 0;
    @(posedge clk); @(negedge clk);
    bus.s00_awvalid = 0;
    check("c1_awready", 64'(bus.s00_awready), 0);
    check("c1_bvalid",  64'(bus.s00_bvalid), 0);
    @(negedge clk);
    @(negedge clk);
    check("c3_wready", 64'(bus.s00_wready), 1);
    bus.s00_wdata = 32'h1; bus.s00_wstrb = 4'hF; bus.s00_wvalid = 1;
    @(posedge clk); @(negedge clk);
    bus.s00_wvalid = 0;
    check("c4_bvalid", 64'(bus.s00_bvalid), 0);
    check("c4_msip",   64'(msip), 0);
    @(negedge clk);
    check("c5_bvalid", 64'(bus.s00_bvalid), 1);
    check("c5_bresp",  64'(bus.s00_bresp), 0);
    check("c5_msip",   64'(msip), 1);
    @(negedge clk);
    check("c6_bvalid_hold", 64'(bus.s00_bvalid), 1);
    check("c6_awready",     64'(bus.s00_awready), 0);
    check("c6_wready",      64'(bus.s00_wready), 0);
    bus.s00_bready = 1;
    @(negedge clk);
    check("c7_bvalid",  64'(bus.s00_bvalid), 0);
    check("c7_awready", 64'(bus.s00_awready), 1);

    // msip register: only bit 0 stored, byte 0 strobe required
    axi_read(16'h0000, d, r, rv);
    check("msip_rd", 64'(d), 1);
    axi_write(16'h0000, 32'hFFFF_FFFE, 4'hF, r);
    check("msip_clr", 64'(msip), 0);
    axi_write(16'h0000, 32'hFFFF_FFFF, 4'hF, r);
    axi_read(16'h0000, d, r, rv);
    check("msip_rd_upper0", 64'(d), 1);
    axi_write(16'h0000, 32'h0, 4'hE, r);
    check("msip_strb_skip", 64'(msip), 1);

    // Unmapped / misaligned accesses
    axi_read(16'h1234, d, r, rv);
    check("unmap_rvalid_next", 64'(rv), 1);
    check("unmap_rresp", 64'(r), 2);
    check("unmap_rdata", 64'(d), 0);
    axi_write(16'h0008, 32'h1, 4'hF, r);
    check("unmap_bresp", 64'(r), 2);
    axi_write(16'h4002, 32'hFF, 4'hF, r);
    check("misal_bresp", 64'(r), 2);
    axi_read(16'h4000, d, r, rv);
    check("cmp_lo_kept", 64'(d), 32'h10);
    check("cmp_lo_rresp", 64'(r), 0);
    axi_read(16'h4004, d, r, rv);
    check("cmp_hi_kept", 64'(d), 0);
    axi_read(16'hBFF9, d, r, rv);
    check("misal_rresp", 64'(r), 2);

    // mtime strobe merge while ticking: lo 0x1234_0002 -> 0x1234_FFFF, read one tick later
    axi_write(16'hBFFC, 32'hA5, 4'hF, r);
    axi_write(16'hBFF8, 32'h1234_0000, 4'hF, r);
    axi_write(16'hBFF8, 32'hFFFF_FFFF, 4'h3, r);
    check("mtime_strb_bresp", 64'(r), 0);
    axi_read(16'hBFF8, d, r, rv);
    check("mtime_lo_merge", 64'(d), 32'h1235_0000);
    axi_read(16'hBFFC, d, r, rv);
    check("mtime_hi_kept", 64'(d), 32'hA5);
    check("mtip_high_time", 64'(mtip), 1);

    // rready stall on mtimecmp lo
    check("stall_arready0", 64'(bus.s00_arready), 1);
    bus.s00_araddr = 32'h4000; bus.s00_arvalid = 1;
    @(posedge clk); @(negedge clk);
    bus.s00_arvalid = 0; bus.s00_rready = 0;
    for (int i = 0; i < 5; i++) begin
      check("stall_rvalid",  64'(bus.s00_rvalid), 1);
      check("stall_rdata",   64'(bus.s00_rdata), 32'h10);
      check("stall_arready", 64'(bus.s00_arready), 0);
      @(negedge clk);
    end
    bus.s00_rready = 1;
    @(posedge clk); @(negedge clk);
    check("stall_done_rvalid",  64'(bus.s00_rvalid), 0);
    check("stall_done_arready", 64'(bus.s00_arready), 1);

    // Reset while in RESP
    bus.s00_awaddr = 32'h4000; bus.s00_wdata = 32'h0; bus.s00_wstrb = 4'hF;
    bus.s00_bready = 0; bus.s00_awvalid = 1; bus.s00_wvalid = 1;
    @(posedge clk); @(negedge clk);
    bus.s00_awvalid = 0; bus.s00_wvalid = 0;
    @(negedge clk);
    check("resp_bvalid", 64'(bus.s00_bvalid), 1);
    rst = 1;
    @(posedge clk); @(negedge clk);
    rst = 0;
    check("rst_mid_bvalid",  64'(bus.s00_bvalid), 0);
    check("rst_mid_awready", 64'(bus.s00_awready), 1);
    check("rst_mid_wready",  64'(bus.s00_wready), 1);
    check("rst_mid_msip",    64'(msip), 0);
    bus.s00_bready = 1;
    axi_read(16'h4000, d, r, rv);
    check("rst_cmp_lo", 64'(d), 32'hFFFF_FFFF);
    axi_read(16'h4004, d, r, rv);
    check("rst_cmp_hi", 64'(d), 32'hFFFF_FFFF);
    check("rst_no_bvalid", 64'(bus.s00_bvalid), 0);
    check("rst_mtip_low", 64'(mtip), 0);

    // Byte strobes on mtimecmp
    axi_write(16'h4000, 32'h1122_3344, 4'hF, r);
    axi_write(16'h4000, 32'hAABB_CCDD, 4'h4, r);
    axi_read(16'h4000, d, r, rv);
    check("cmp_strb_merge", 64'(d), 32'h11BB_3344);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rvee_clint.md
RVEE_CLINT -- requirements
Module: rvee_clint

Interface
REQ-001 SHALL have parameter AWIDTH, default 32: AXI address width; only bits [15:0] are decoded.
REQ-002 SHALL have parameter DWIDTH, default 32: data width; 32 is the only supported value.
REQ-003 SHALL have parameter PRESCALE, default 1: clk cycles per mtime tick, legal range 1..65535.
REQ-004 SHALL have port clk, input, 1: the single clock.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port s00_awaddr, input, AWIDTH: write address.
REQ-007 SHALL have port s00_awvalid / s00_awready, in/out, 1 each: AW handshake.
REQ-008 SHALL have port s00_wdata, input, DWIDTH: write data.
REQ-009 SHALL have port s00_wstrb, input, DWIDTH/8: byte enables.
REQ-010 SHALL have port s00_wvalid / s00_wready, in/out, 1 each: W handshake.
REQ-011 SHALL have port s00_bresp, output, 2: write response.
REQ-012 SHALL have port s00_bvalid / s00_bready, out/in, 1 each: B handshake.
REQ-013 SHALL have port s00_araddr, input, AWIDTH: read address.
REQ-014 SHALL have port s00_arvalid / s00_arready, in/out, 1 each: AR handshake.
REQ-015 SHALL have port s00_rdata / s00_rresp, output, DWIDTH / 2: read data and response.
REQ-016 SHALL have port s00_rvalid / s00_rready, out/in, 1 each: R handshake.
REQ-017 SHALL have port msip, output, 1: machine software interrupt, level.
REQ-018 SHALL have port mtip, output, 1: machine timer interrupt, level.
REQ-019 SHALL have no AxPROT ports; protection is ignored.

Function
REQ-020 SHALL act as the AXI4-Lite responder to the core's MEM master port; the register map is 0x0000 msip (bit 0, bits 31:1 read 0), 0x4000/0x4004 mtimecmp lo/hi, 0xBFF8/0xBFFC mtime lo/hi.
REQ-021 SHALL accept AW and W independently: awready=1 while no AW is held, wready=1 while no W is held, each captured into its own holding register.
REQ-022 SHALL perform the write in the cycle after both AW and W are held, honouring wstrb per byte, then assert bvalid with bresp=OKAY (2'b00), or SLVERR (2'b10) for an unmapped or misaligned address, with no register changed in that case.
REQ-023 SHALL hold bvalid and bresp stable until bready; awready and wready SHALL stay low from the write until the B handshake.
REQ-024 SHALL use a write FSM with states IDLE, HAVE_AW, HAVE_W, RESP, moving to RESP one cycle after both halves are held, and back to IDLE on bvalid&&bready.
REQ-025 SHALL set arready=1 in read state IDLE, move to RDATA on arvalid, and drive rvalid exactly one cycle after the AR handshake with the sampled register value and OKAY, or rdata=0 and SLVERR for an unmapped address.
REQ-026 SHALL hold rdata, rresp and rvalid stable until rready, then return to IDLE; arready SHALL be 0 in RDATA.
REQ-027 SHALL run reads and writes concurrently; a read and a write to the same register completing in the same cycle returns the pre-write value.
REQ-028 SHALL increment the 64-bit mtime by 1 every PRESCALE clk cycles, wrapping from 2^64-1 to 0.
REQ-029 SHALL give a software write to mtime priority over the increment in the same cycle, with the written bytes taking effect and unwritten bytes keeping their pre-increment value.
REQ-030 SHALL drive mtip as a register equal to (mtime >= mtimecmp) as an unsigned 64-bit comparison, updated one cycle after either operand changes.
REQ-031 SHALL drive msip directly from msip register bit 0.

Reset
REQ-032 SHALL, on rst, clear awready, wready and arready to 1, clear bvalid and rvalid to 0, bresp, rresp and rdata to 0, both FSMs to IDLE, mtime to 0, mtimecmp to all ones, msip to 0, mtip to 0, and the prescaler to 0.
REQ-033 SHALL abandon any in-flight transaction when rst is asserted mid-transfer, with no response ever issued for it.

Structure
REQ-034 SHALL place the register offsets, RESP_OKAY/RESP_SLVERR and the FSM state enums in package rvee_clint_pkg.
REQ-035 SHALL implement the mtime counter and prescaler in one sub-module, rvee_clint_timer.

Verification
REQ-036 SHALL cover this scenario: AW at cycle 0 and W at cycle 3 to 0x0 with data 1 and wstrb 0xF -> bvalid at cycle 5 with OKAY, and msip=1 from cycle 5.
REQ-037 SHALL cover this scenario: write mtimecmp = 0x10 with PRESCALE=1 after reset -> mtip rises one cycle after mtime reaches 0x10.
REQ-038 SHALL cover this scenario: read 0x1234 -> rvalid one cycle after AR with rresp=2'b10 and rdata=0.
REQ-039 SHALL cover this scenario: write mtime lo = 0xFFFFFFFF with wstrb 0x3 while the counter ticks -> only bytes 1:0 are replaced and the hi word is unchanged.
REQ-040 SHALL cover this scenario: rready held low for 5 cycles -> rdata and rvalid stable and arready=0 throughout.
REQ-041 SHALL cover this scenario: rst pulsed while in state RESP -> bvalid=0 and mtimecmp=0xFFFFFFFF_FFFFFFFF on release.
